vdma_frame_addr_gen: RTL
========================

// Module: vdma_frame_addr_gen
// PURPOSE
//  Downstream consumer of a frame-slot pointer (write.point / rdN.point) from the triple-buffer base-address arbiter.
//  - On each frame start (vs rising edge), latches the pointer.
//  - Converts it to an AXI frame base address.
//  - Walks the frame line by line, issuing burst commands (addr + AXI len) to the VDMA AXI master through a valid/ready handshake.
//  - One instance per VDMA port (write and each read channel).
// PARAMETERS
//  ADDR_W       32            AXI address width
//  DATA_BYTES   8             bytes per AXI beat (power of 2)
//  BURST_BEATS  16            max beats per burst (1..256)
//  NUM_FRAMES   3             frame slots; pointer values >= NUM_FRAMES map to slot 0
//  BASE_ADDR    32'h1000_0000 address of slot 0
//  FRAME_STRIDE 32'h0080_0000 bytes between slots
//  LINE_STRIDE  4096          bytes between line starts
//  H_BYTES      3840          active bytes per line; must be a multiple of DATA_BYTES
//  V_LINES      1080          lines per frame (>=1)
// PORTS
//  clk          in   1       clock; all logic single domain
//  rst_n        in   1       asynchronous active-low reset
//  enable       in   1       frame acceptance enable; sampled at vs edge
//  vs           in   1       frame sync level, synchronous to clk
//  point        in   3       frame slot index from base-address arbiter
//  cmd_valid    out  1       burst command valid
//  cmd_ready    in   1       burst command accepted by AXI master
//  cmd_addr     out  ADDR_W  burst start byte address
//  cmd_len      out  8       AXI len (beats-1)
//  cmd_eol      out  1       command is last burst of its line
//  frame_busy   out  1       high from frame capture until last command accepted
//  frame_done   out  1       one-cycle pulse after last command of frame accepted
//  overrun      out  1       only with VDMA_ADDR_OVERRUN_EN; sticky error flag
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; vs_d=0; counters 0.
//  vs_d registers vs; edge = vs & ~vs_d.
//  FSM IDLE -> ISSUE -> IDLE.
//  IDLE:
//  - Frame capture: edge & enable in cycle N.
//  - Registers frame_base = BASE_ADDR + slot*FRAME_STRIDE (ADDR_W bits, modulo 2^ADDR_W).
//  - Clears line=0, offset=0. Enters ISSUE.
//  - cmd_valid=1 and frame_busy=1 from cycle N+1.
//  - edge with enable=0: ignored.
//  ISSUE:
//  - cmd_addr = frame_base + line*LINE_STRIDE + offset.
//  - beats = min((H_BYTES-offset)/DATA_BYTES, BURST_BEATS); cmd_len = beats-1.
//  - cmd_eol = (offset + beats*DATA_BYTES == H_BYTES).
//  - Handshake: cmd_valid, addr, len and eol stay stable until cmd_ready. Fire = valid & ready.
//  - Next command is valid the cycle after fire; no bubbles, so back-to-back ready gives one command per cycle.
//  - Fire & !eol: offset += beats*DATA_BYTES.
//  - Fire & eol & line<V_LINES-1: line++, offset=0.
//  - Fire & eol & line==V_LINES-1: next cycle cmd_valid=0, frame_busy=0, frame_done=1 for 1 cycle; return to IDLE.
//  - Bursts never cross the 4KB boundary relative to line start, provided LINE_STRIDE is a multiple of 4096.
//  - edge during ISSUE: ignored; the current frame always completes.
//  - enable deasserted during ISSUE: the current frame completes.
//  - edge in the same cycle as the final fire: ignored; no capture until IDLE.
//  - Async reset mid-frame: immediately IDLE with all outputs 0; pending command dropped.
// CONFIGURATION
//  VDMA_ADDR_OVERRUN_EN defined:
//  - Port overrun exists.
//  - Set in the cycle after any edge & enable seen while in ISSUE, including the final-fire cycle.
//  - Stays set until rst_n or enable=0.
//  - Frame sequencing is unchanged.
//  VDMA_ADDR_OVERRUN_EN undefined: port and logic absent; late edges silently ignored.
// TESTING
//  Bench params: BASE 0x1000_0000, FRAME_STRIDE 0x1000, LINE_STRIDE 0x100, H_BYTES 160, DATA_BYTES 8, BURST_BEATS 16, V_LINES 2.
//  T1 vs edge, enable=1, point=1, ready=1 -> commands {0x1000_1000,len15,eol0}, {0x1000_1080,len3,eol1},
//     {0x1000_1100,len15,eol0}, {0x1000_1180,len3,eol1}; first valid 1 cycle after edge; frame_done pulse 1 cycle after 4th fire.
//  T2 point=2, ready toggling random -> same 4-command pattern at base 0x1000_2000; addr/len stable while valid & !ready.
//  T3 point=5 -> slot 0, first cmd_addr 0x1000_0000. enable=0 at edge -> no commands, frame_busy stays 0.
//  T4 second vs edge after 2nd command accepted -> frame still ends at 4 commands, no restart.
//     With VDMA_ADDR_OVERRUN_EN: overrun=1 next cycle, cleared by enable=0.
//  T5 rst_n low after 3rd command issued -> cmd_valid=0, frame_busy=0 immediately.
//     Next edge with point=0 restarts cleanly at 0x1000_0000.

Source files
------------

// File: rtl/vdma_frame_addr_gen.sv
// vdma_frame_addr_gen: latches a frame-slot pointer on vs rise and walks the frame as AXI line bursts.
// Optional sticky late-frame flag on port overrun: define VDMA_ADDR_OVERRUN_EN.
module vdma_frame_addr_gen #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_BYTES   = 8,
    parameter int                BURST_BEATS  = 16,
    parameter int                NUM_FRAMES   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 32'h0080_0000,
    parameter int                LINE_STRIDE  = 4096,
    parameter int                H_BYTES      = 3840,
    parameter int                V_LINES      = 1080
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              vs,
    input  logic [2:0]        point,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic              cmd_eol,
    output logic              frame_busy,
`ifdef VDMA_ADDR_OVERRUN_EN
    output logic              overrun,
`endif
    output logic              frame_done
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam int OW = $clog2(H_BYTES + 1);
    localparam int LW = $clog2(V_LINES) > 0 ? $clog2(V_LINES) : 1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, slot;
    logic [LW-1:0]     line_q, line_d;
    logic [OW-1:0]     offset_q, offset_d;
    logic              vs_q, done_q, done_d;
    logic              issue, fire, vs_rise, last;
    logic [31:0]       rem, beats, step;

    always_comb begin
        issue   = state_q == ISSUE;
        fire    = issue & cmd_ready;
        vs_rise = vs & ~vs_q;
        slot    = 32'(point) < 32'(NUM_FRAMES) ? ADDR_W'(point) : '0;
        rem     = (32'(H_BYTES) - 32'(offset_q)) / 32'(DATA_BYTES);
        beats   = rem > 32'(BURST_BEATS) ? 32'(BURST_BEATS) : rem;
        step    = beats * 32'(DATA_BYTES);
        last    = 32'(offset_q) + step == 32'(H_BYTES);
    end

    assign cmd_valid  = issue;
    assign frame_busy = issue;
    assign frame_done = done_q;
    assign cmd_addr   = issue ? base_q + ADDR_W'(line_q) * ADDR_W'(LINE_STRIDE) + ADDR_W'(offset_q) : '0;
    assign cmd_len    = issue ? 8'(beats - 32'd1) : '0;
    assign cmd_eol    = issue & last;

    // Captures only from IDLE, so edges during a frame (even on its final fire) are dropped.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        line_d   = line_q;
        offset_d = offset_q;
        done_d   = 1'b0;
        if (!issue) begin
            if (vs_rise & enable) begin
                state_d  = ISSUE;
                base_d   = BASE_ADDR + slot * FRAME_STRIDE;
                line_d   = '0;
                offset_d = '0;
            end
        end else if (fire) begin
            if (!last) begin
                offset_d = offset_q + OW'(step);
            end else if (line_q != LW'(V_LINES - 1)) begin
                line_d   = line_q + LW'(1);
                offset_d = '0;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            line_q   <= '0;
            offset_q <= '0;
            vs_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            line_q   <= line_d;
            offset_q <= offset_d;
            vs_q     <= vs;
            done_q   <= done_d;
        end
    end

`ifdef VDMA_ADDR_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= enable & (overrun_q | (issue & vs_rise));
    end

    assign overrun = overrun_q;
`endif
endmodule
